ahbl_irq_ctrl: RTL and testbench

AHB-Lite slave interrupt controller that collects peripheral interrupt lines (I2S, DMA, timer, UART, GPIO) and drives the single `IRQ` input of the Hazard2 CPU. Sits on a crossbar slave port at 0xA000_0000. Provides per-source synchronisation, pending/enable masking, optional edge latching and a lowest-index-wins claim register. Replaces the direct DMA→CPU IRQ wire in the SoC top.

---
 rtl/ahbl_irq_ctrl.sv | 144 ++++++++++++++
 tb/tb_ahbl_irq_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahbl_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ahbl_irq_ctrl
//  Description : AHB-Lite interrupt controller (sync, pend/enable, claim ID).
//                Define IRQCTL_EDGE_EN to add per-source edge triggering.
//  Revision    : 1.0 - initial release
// ============================================================================
module ahbl_irq_ctrl #(
    parameter int N_SRC = 8
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic [31:0]      HADDR,
    input  logic [1:0]       HTRANS,
    input  logic [2:0]       HSIZE,
    input  logic             HWRITE,
    input  logic             HREADY,
    input  logic             HSEL,
    input  logic [31:0]      HWDATA,
    output logic             HREADYOUT,
    output logic [31:0]      HRDATA,
    input  logic [N_SRC-1:0] IRQ_IN,
    output logic             IRQ
);

    localparam logic [2:0] C_A_PEND   = 3'd0;
    localparam logic [2:0] C_A_ENABLE = 3'd1;
    localparam logic [2:0] C_A_TRIG   = 3'd2;
    localparam logic [2:0] C_A_CLAIM  = 3'd3;
    localparam logic [2:0] C_A_RAW    = 3'd4;
    localparam logic [2:0] C_A_GCTRL  = 3'd5;

    logic [N_SRC-1:0] r_sync1;
    logic [N_SRC-1:0] r_sync2;
    logic [N_SRC-1:0] r_pend;
    logic [N_SRC-1:0] r_enable;
    logic             r_gie;
    logic             r_irq;
    logic             r_dp_valid;
    logic             r_dp_write;
    logic [2:0]       r_dp_addr;

    logic             w_accept;
    logic             w_wr;
    logic [N_SRC-1:0] w_act;
    logic [N_SRC-1:0] w_pend_nxt;
    logic [N_SRC-1:0] w_trig_rd;
    logic [4:0]       w_claim_id;

    wire w_unused = ^{HSIZE, HADDR[31:5], HADDR[1:0], HTRANS[0], HWDATA};

    assign HREADYOUT = 1'b1;
    assign w_accept  = HSEL & HREADY & HTRANS[1];
    assign w_wr      = r_dp_valid & r_dp_write;
    assign w_act     = r_pend & r_enable;
    assign IRQ       = r_irq;

    always_comb begin
        w_claim_id = 5'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (w_act[i]) w_claim_id = 5'(i + 1);
        end
    end

`ifdef IRQCTL_EDGE_EN
    logic [N_SRC-1:0] r_trig;
    logic [N_SRC-1:0] r_raw_d;
    logic [N_SRC-1:0] w_rise;
    logic [N_SRC-1:0] w_clr;

    // Clears come from PEND W1C or a CLAIM completion write; a same-cycle rise wins.
    always_comb begin
        w_clr = '0;
        if (w_wr && r_dp_addr == C_A_PEND) begin
            w_clr = HWDATA[N_SRC-1:0];
        end
        if (w_wr && r_dp_addr == C_A_CLAIM) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (HWDATA == 32'(i + 1)) w_clr[i] = 1'b1;
            end
        end
    end

    assign w_rise     = r_sync2 & ~r_raw_d;
    assign w_pend_nxt = (r_trig & ((r_pend & ~w_clr) | w_rise)) | (~r_trig & r_sync2);
    assign w_trig_rd  = r_trig;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_trig  <= '0;
            r_raw_d <= '0;
        end else begin
            r_raw_d <= r_sync2;
            if (w_wr && r_dp_addr == C_A_TRIG) r_trig <= HWDATA[N_SRC-1:0];
        end
    end
`else
    assign w_pend_nxt = r_sync2;
    assign w_trig_rd  = '0;
`endif

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_pend     <= '0;
            r_enable   <= '0;
            r_gie      <= 1'b0;
            r_irq      <= 1'b0;
            r_dp_valid <= 1'b0;
            r_dp_write <= 1'b0;
            r_dp_addr  <= 3'd0;
        end else begin
            r_sync1 <= IRQ_IN;
            r_sync2 <= r_sync1;
            r_pend  <= w_pend_nxt;
            r_irq   <= r_gie & (|w_act);
            if (HREADY) begin
                r_dp_valid <= w_accept;
                r_dp_write <= HWRITE;
                r_dp_addr  <= HADDR[4:2];
            end
            if (w_wr && r_dp_addr == C_A_ENABLE) r_enable <= HWDATA[N_SRC-1:0];
            if (w_wr && r_dp_addr == C_A_GCTRL)  r_gie    <= HWDATA[0];
        end
    end

    always_comb begin
        HRDATA = 32'd0;
        if (r_dp_valid && !r_dp_write) begin
            case (r_dp_addr)
                C_A_PEND:   HRDATA = 32'(r_pend);
                C_A_ENABLE: HRDATA = 32'(r_enable);
                C_A_TRIG:   HRDATA = 32'(w_trig_rd);
                C_A_CLAIM:  HRDATA = 32'(w_claim_id);
                C_A_RAW:    HRDATA = 32'(r_sync2);
                C_A_GCTRL:  HRDATA = {31'd0, r_gie};
                default:    HRDATA = 32'd0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahbl_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ahbl_irq_ctrl
//  Description : Directed self-checking bench for ahbl_irq_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ahbl_irq_ctrl;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic [31:0] HADDR = '0;
    logic [1:0]  HTRANS = 2'b00;
    logic [2:0]  HSIZE = 3'd2;
    logic        HWRITE = 1'b0;
    logic        HREADY = 1'b1;
    logic        HSEL = 1'b0;
    logic [31:0] HWDATA = '0;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic [7:0]  IRQ_IN = '0;
    logic        IRQ;

    int vectors = 0;
    int errors  = 0;

    ahbl_irq_ctrl #(.N_SRC(8)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HWRITE(HWRITE), .HREADY(HREADY), .HSEL(HSEL),
        .HWDATA(HWDATA), .HREADYOUT(HREADYOUT), .HRDATA(HRDATA),
        .IRQ_IN(IRQ_IN), .IRQ(IRQ)
    );

    always #5 HCLK = ~HCLK;

    // Tasks start and return 1 time unit after a rising edge.
    task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
        @(posedge HCLK); #1;
    endtask

    task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        d = HRDATA;
        @(posedge HCLK); #1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge HCLK); #1;
        end
    endtask

    task automatic test_reset;
        logic [31:0] d;
        HRESETn = 1'b0;
        cycles(3);
        HRESETn = 1'b1;
        cycles(1);
        vectors++; if (IRQ !== 1'b0) begin errors++; $display("FAIL reset_irq got %0h want 0", IRQ); end
        vectors++; if (HREADYOUT !== 1'b1) begin errors++; $display("FAIL reset_hreadyout got %0h want 1", HREADYOUT); end
        vectors++; if (HRDATA !== 32'h0) begin errors++; $display("FAIL reset_hrdata got %0h want 0", HRDATA); end
        ahb_read(32'hA000_0000, d);
        vectors++; if (d !== 32'h0) begin errors++; $display("FAIL reset_pend got %0h want 0", d); end
        ahb_read(32'hA000_0004, d);
        vectors++; if (d !== 32'h0) begin errors++; $display("FAIL reset_enable got %0h want 0", d); end
        ahb_read(32'hA000_0014, d);
        vectors++; if (d !== 32'h0) begin errors++; $display("FAIL reset_gctrl got %0h want 0", d); end
    endtask

    task automatic test_level;
        logic [31:0] d;
        ahb_write(32'hA000_0004, 32'h01);
        ahb_write(32'hA000_0014, 32'h01);
        IRQ_IN = 8'h01;
        for (int k = 1; k <= 4; k++) begin
            @(posedge HCLK); #1;
            vectors++;
            if (IRQ !== (k == 4)) begin errors++; $display("FAIL level_rise_edge%0d got %0h want %0h", k, IRQ, (k == 4)); end
        end
        ahb_read(32'hA000_000C, d);
        vectors++; if (d !== 32'd1) begin errors++; $display("FAIL level_claim got %0h want 1", d); end
        ahb_read(32'hA000_0000, d);
        vectors++; if (d !== 32'h01) begin errors++; $display("FAIL level_pend got %0h want 1", d); end
        IRQ_IN = 8'h00;
        for (int k = 1; k <= 4; k++) begin
            @(posedge HCLK); #1;
            vectors++;
            if (IRQ !== (k != 4)) begin errors++; $display("FAIL level_fall_edge%0d got %0h want %0h", k, IRQ, (k != 4)); end
        end
    endtask

    task automatic test_priority;
        logic [31:0] d;
        ahb_write(32'hA000_0004, 32'hFF);
        IRQ_IN = 8'hA0;
        cycles(4);
        ahb_read(32'hA000_000C, d);
        vectors++; if (d !== 32'd6) begin errors++; $display("FAIL prio_a0 got %0d want 6", d); end
        IRQ_IN = 8'hA8;
        cycles(4);
        ahb_read(32'hA000_000C, d);
        vectors++; if (d !== 32'd4) begin errors++; $display("FAIL prio_a8 got %0d want 4", d); end
        IRQ_IN = 8'h00;
        cycles(4);
    endtask

    task automatic test_masking;
        logic [31:0] d;
        ahb_write(32'hA000_0004, 32'h00);
        IRQ_IN = 8'hFF;
        cycles(5);
        vectors++; if (IRQ !== 1'b0) begin errors++; $display("FAIL mask_irq got %0h want 0", IRQ); end
        ahb_read(32'hA000_000C, d);
        vectors++; if (d !== 32'd0) begin errors++; $display("FAIL mask_claim got %0d want 0", d); end
        ahb_read(32'hA000_0010, d);
        vectors++; if (d !== 32'hFF) begin errors++; $display("FAIL mask_raw got %0h want ff", d); end
        ahb_write(32'hA000_0014, 32'h00);
        ahb_write(32'hA000_0004, 32'hFF);
        cycles(2);
        vectors++; if (IRQ !== 1'b0) begin errors++; $display("FAIL mask_gie_off got %0h want 0", IRQ); end
        ahb_read(32'hA000_000C, d);
        vectors++; if (d !== 32'd1) begin errors++; $display("FAIL mask_claim_gie_off got %0d want 1", d); end
        ahb_write(32'hA000_0014, 32'h01);
        vectors++; if (IRQ !== 1'b0) begin errors++; $display("FAIL gie_same_edge got %0h want 0", IRQ); end
        cycles(1);
        vectors++; if (IRQ !== 1'b1) begin errors++; $display("FAIL gie_next_edge got %0h want 1", IRQ); end
        IRQ_IN = 8'h00;
        ahb_write(32'hA000_0004, 32'h00);
        cycles(4);
    endtask

    task automatic test_bus;
        logic [31:0] d;
        ahb_write(32'hA000_0004, 32'h0F);
        // IDLE and BUSY with select and write asserted must not write
        for (int t = 0; t < 2; t++) begin
            HSEL = 1'b1; HWRITE = 1'b1; HADDR = 32'hA000_0004; HTRANS = 2'(t);
            @(posedge HCLK); #1;
            HSEL = 1'b0; HWRITE = 1'b0; HTRANS = 2'b00; HWDATA = 32'hAA;
            @(posedge HCLK); #1;
        end
        ahb_read(32'hA000_0004, d);
        vectors++; if (d !== 32'h0F) begin errors++; $display("FAIL idle_busy_nowrite got %0h want 0f", d); end
        HSIZE = 3'd0;
        ahb_write(32'hA000_0004, 32'hFFFF_FF3C);
        HSIZE = 3'd2;
        ahb_read(32'hA000_0004, d);
        vectors++; if (d !== 32'h3C) begin errors++; $display("FAIL hsize_ignored got %0h want 3c", d); end
        ahb_write(32'hA000_0014, 32'hFFFF_FFFE);
        ahb_read(32'hA000_0014, d);
        vectors++; if (d !== 32'h0) begin errors++; $display("FAIL gctrl_bit0 got %0h want 0", d); end
        vectors++; if (HRDATA !== 32'h0) begin errors++; $display("FAIL hrdata_idle got %0h want 0", HRDATA); end
        ahb_write(32'hA000_001C, 32'hDEAD_BEEF);
        ahb_read(32'hA000_0018, d);
        vectors++; if (d !== 32'h0) begin errors++; $display("FAIL read_18 got %0h want 0", d); end
        ahb_read(32'hA000_001C, d);
        vectors++; if (d !== 32'h0) begin errors++; $display("FAIL read_1c got %0h want 0", d); end
        vectors++; if (HREADYOUT !== 1'b1) begin errors++; $display("FAIL hreadyout got %0h want 1", HREADYOUT); end
        ahb_write(32'hA000_0004, 32'h00);
    endtask

    task automatic test_back_to_back;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'hA000_0004;
        @(posedge HCLK); #1;
        HWDATA = 32'h5A; HWRITE = 1'b0; HADDR = 32'hA000_0004;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        vectors++; if (HRDATA !== 32'h5A) begin errors++; $display("FAIL b2b_enable got %0h want 5a", HRDATA); end
        @(posedge HCLK); #1;
        ahb_write(32'hA000_0004, 32'h00);
    endtask

`ifdef IRQCTL_EDGE_EN
    task automatic test_edge;
        logic [31:0] d;
        ahb_write(32'hA000_0008, 32'h04);
        ahb_read(32'hA000_0008, d);
        vectors++; if (d !== 32'h04) begin errors++; $display("FAIL trig_rw got %0h want 04", d); end
        ahb_write(32'hA000_0004, 32'h04);
        ahb_write(32'hA000_0014, 32'h01);
        IRQ_IN = 8'h04; cycles(2); IRQ_IN = 8'h00;
        cycles(6);
        ahb_read(32'hA000_0000, d);
        vectors++; if (d !== 32'h04) begin errors++; $display("FAIL edge_latched got %0h want 04", d); end
        vectors++; if (IRQ !== 1'b1) begin errors++; $display("FAIL edge_irq got %0h want 1", IRQ); end
        ahb_write(32'hA000_0000, 32'h04);
        cycles(1);
        vectors++; if (IRQ !== 1'b0) begin errors++; $display("FAIL w1c_irq got %0h want 0", IRQ); end
        ahb_read(32'hA000_0000, d);
        vectors++; if (d !== 32'h0) begin errors++; $display("FAIL w1c_pend got %0h want 0", d); end
    endtask

    task automatic test_set_clear;
        logic [31:0] d;
        IRQ_IN = 8'h04; cycles(2); IRQ_IN = 8'h00;
        cycles(4);
        IRQ_IN = 8'h04;
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'hA000_000C;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'd3;
        @(posedge HCLK); #1;
        IRQ_IN = 8'h00;
        ahb_read(32'hA000_0000, d);
        vectors++; if (d !== 32'h04) begin errors++; $display("FAIL set_wins got %0h want 04", d); end
        ahb_write(32'hA000_000C, 32'd3);
        ahb_read(32'hA000_0000, d);
        vectors++; if (d !== 32'h0) begin errors++; $display("FAIL claim_complete got %0h want 0", d); end
        ahb_write(32'hA000_0008, 32'h00);
        ahb_write(32'hA000_0004, 32'h00);
    endtask
`else
    task automatic test_macro_off;
        logic [31:0] d;
        ahb_write(32'hA000_0008, 32'hFF);
        ahb_read(32'hA000_0008, d);
        vectors++; if (d !== 32'h0) begin errors++; $display("FAIL trig_absent got %0h want 0", d); end
        ahb_write(32'hA000_0004, 32'h04);
        ahb_write(32'hA000_0014, 32'h01);
        IRQ_IN = 8'h04; cycles(2); IRQ_IN = 8'h00;
        cycles(6);
        ahb_read(32'hA000_0000, d);
        vectors++; if (d !== 32'h0) begin errors++; $display("FAIL no_edge_latch got %0h want 0", d); end
        vectors++; if (IRQ !== 1'b0) begin errors++; $display("FAIL no_edge_irq got %0h want 0", IRQ); end
        ahb_write(32'hA000_0004, 32'h01);
        IRQ_IN = 8'h01;
        cycles(4);
        ahb_write(32'hA000_0000, 32'h01);
        ahb_write(32'hA000_000C, 32'd1);
        ahb_read(32'hA000_0000, d);
        vectors++; if (d !== 32'h01) begin errors++; $display("FAIL level_no_clear got %0h want 01", d); end
        vectors++; if (IRQ !== 1'b1) begin errors++; $display("FAIL level_irq_held got %0h want 1", IRQ); end
        IRQ_IN = 8'h00;
        ahb_write(32'hA000_0004, 32'h00);
        cycles(4);
    endtask
`endif

    task automatic test_reset_mid_write;
        logic [31:0] d;
        ahb_write(32'hA000_0004, 32'h33);
        ahb_write(32'hA000_0014, 32'h01);
        IRQ_IN = 8'h01;
        cycles(5);
        vectors++; if (IRQ !== 1'b1) begin errors++; $display("FAIL pre_reset_irq got %0h want 1", IRQ); end
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'hA000_0004;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'hFF;
        HRESETn = 1'b0;
        #1;
        vectors++; if (IRQ !== 1'b0) begin errors++; $display("FAIL async_reset_irq got %0h want 0", IRQ); end
        IRQ_IN = 8'h00;
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        cycles(1);
        vectors++; if (HRDATA !== 32'h0) begin errors++; $display("FAIL mid_reset_hrdata got %0h want 0", HRDATA); end
        ahb_read(32'hA000_0004, d);
        vectors++; if (d !== 32'h0) begin errors++; $display("FAIL mid_reset_enable got %0h want 0", d); end
        ahb_read(32'hA000_0014, d);
        vectors++; if (d !== 32'h0) begin errors++; $display("FAIL mid_reset_gctrl got %0h want 0", d); end
        ahb_read(32'hA000_0000, d);
        vectors++; if (d !== 32'h0) begin errors++; $display("FAIL mid_reset_pend got %0h want 0", d); end
    endtask

    initial begin
        test_reset();
        test_level();
        test_priority();
        test_masking();
        test_bus();
        test_back_to_back();
`ifdef IRQCTL_EDGE_EN
        test_edge();
        test_set_clear();
`else
        test_macro_off();
`endif
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
